// File: rtl/hoplite_pkg.sv
// hoplite_pkg: packet field layout, field extractors and sink FSM states shared by generator and sink
package hoplite_pkg;
  localparam int X_AW    = 2;
  localparam int Y_AW    = 2;
  localparam int A_W     = X_AW + Y_AW;
  localparam int P_W     = 16;
  localparam int SEQ_W   = P_W - 2 * A_W;
  localparam int SEQ_LSB = 0;
  localparam int SRC_LSB = SEQ_W;
  localparam int DST_LSB = SEQ_W + A_W;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  function automatic logic [31:0] field(input logic [31:0] pkt, input int lsb, input int w);
    return (pkt >> lsb) & ((32'd1 << w) - 32'd1);
  endfunction
  function automatic logic [31:0] get_dst(input logic [31:0] pkt, input int a_w = A_W, input int p_w = P_W);
    return field(pkt, p_w - a_w, a_w);
  endfunction
  function automatic logic [31:0] get_src(input logic [31:0] pkt, input int a_w = A_W, input int p_w = P_W);
    return field(pkt, p_w - 2 * a_w, a_w);
  endfunction
  function automatic logic [31:0] get_seq(input logic [31:0] pkt, input int a_w = A_W, input int p_w = P_W);
    return field(pkt, 0, p_w - 2 * a_w);
  endfunction
endpackage

// File: rtl/pe_sink_checker_if.sv
// pe_sink_checker_if: switch exit-port packet stream (no backpressure)
interface pe_sink_checker_if #(parameter int P_W = 16);
  logic [P_W-1:0] in_pkt;
  logic           in_vld;
  modport master(output in_pkt, in_vld);
  modport slave(input in_pkt, in_vld);
endinterface

// File: rtl/pe_sink_scoreboard.sv
// pe_sink_scoreboard: per-source seen-bitmap and max-seq table, same-cycle query and update
module pe_sink_scoreboard #(
  parameter int A_W     = 4,
  parameter int SEQ_W   = 8,
  parameter int MAX_SEQ = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [A_W-1:0]   src_i,
  input  logic [SEQ_W-1:0] seq_i,
  input  logic             upd_i,
  output logic             hit_o,
  output logic             reo_o
);
  localparam int N_SRC = 2 ** A_W;
  localparam int NB    = N_SRC * MAX_SEQ;
  logic [NB-1:0]                  bm_q;
  logic [NB-1:0]                  mask;
  logic [N_SRC-1:0]               seen_q;
  logic [N_SRC-1:0][SEQ_W-1:0]    max_q;
  // out-of-range seq selects no bit so it can never alias another source's slot
  always_comb begin
    mask  = (int'(seq_i) < MAX_SEQ) ? NB'(1) << (int'(src_i) * MAX_SEQ + int'(seq_i)) : '0;
    hit_o = |(bm_q & mask);
    reo_o = seen_q[src_i] && (seq_i < max_q[src_i]);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bm_q   <= '0;
      seen_q <= '0;
      max_q  <= '0;
    end else if (upd_i) begin
      bm_q <= bm_q | mask;
      if (!reo_o) begin
        seen_q[src_i] <= 1'b1;
        max_q[src_i]  <= seq_i;
      end
    end
  end
endmodule

// File: rtl/pe_sink_checker.sv
// pe_sink_checker: torus-node receive endpoint; checks ejected packets, counts deliveries,
// flags misroute/range/duplicate/extra errors, and detects completion and inactivity.
module pe_sink_checker #(
  parameter int P_W     = 16,
  parameter int X_AW    = 2,
  parameter int Y_AW    = 2,
  parameter int X_POS   = 0,
  parameter int Y_POS   = 0,
  parameter int MAX_SEQ = 20,
  parameter int EXP_CNT = 20,
  parameter int TIMEOUT = 1000
) (
  input  logic               clk,
  input  logic               rst_n,
  pe_sink_checker_if.slave   ej,
  output logic [15:0]        rcv_cnt,
  output logic [15:0]        reorder_cnt,
  output logic               err_misroute,
  output logic               err_dup,
  output logic               err_range,
  output logic               err_extra,
  output logic               timeout,
  output logic               done
);
  localparam int A_W   = X_AW + Y_AW;
  localparam int SEQ_W = P_W - 2 * A_W;
  localparam int IW    = $clog2(TIMEOUT + 1);
  localparam logic [A_W-1:0] HOME = {X_AW'(X_POS), Y_AW'(Y_POS)};
  import hoplite_pkg::*;
  logic [A_W-1:0]   dst, src;
  logic [SEQ_W-1:0] seq;
  logic             vld, misroute, in_range, hit, reo, accept, to_hit;
  state_t           state_q, state_d;
  logic [15:0]      rcv_q, rcv_d, reo_q, reo_d;
  logic [IW-1:0]    idle_q, idle_d;
  logic             mis_q, dup_q, rng_q, ext_q, to_q;
  assign vld = ej.in_vld;
  assign dst = A_W'(get_dst(32'(ej.in_pkt), A_W, P_W));
  assign src = A_W'(get_src(32'(ej.in_pkt), A_W, P_W));
  assign seq = SEQ_W'(get_seq(32'(ej.in_pkt), A_W, P_W));
  pe_sink_scoreboard #(.A_W(A_W), .SEQ_W(SEQ_W), .MAX_SEQ(MAX_SEQ)) u_sb (
    .clk(clk), .rst_n(rst_n), .src_i(src), .seq_i(seq), .upd_i(accept), .hit_o(hit), .reo_o(reo)
  );
  always_comb begin
    misroute = dst != HOME;
    in_range = int'(seq) < MAX_SEQ;
    accept   = vld && !misroute && in_range && !hit;
    rcv_d    = rcv_q + 16'(accept && rcv_q != '1);
    reo_d    = reo_q + 16'(accept && reo && reo_q != '1);
    state_d  = (state_q != DONE && int'(rcv_d) >= EXP_CNT) ? DONE :
               (state_q == IDLE && vld) ? RUN : state_q;
    idle_d   = (state_q != RUN || vld) ? '0 : idle_q + IW'(idle_q != '1);
    to_hit   = state_q == RUN && !vld && int'(idle_q) >= TIMEOUT - 1;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rcv_q   <= '0;
      reo_q   <= '0;
      idle_q  <= '0;
      mis_q   <= 1'b0;
      dup_q   <= 1'b0;
      rng_q   <= 1'b0;
      ext_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rcv_q   <= rcv_d;
      reo_q   <= reo_d;
      idle_q  <= idle_d;
      mis_q   <= mis_q | (vld && misroute);
      rng_q   <= rng_q | (vld && !misroute && !in_range);
      dup_q   <= dup_q | (vld && !misroute && in_range && hit);
      ext_q   <= ext_q | (accept && state_q == DONE);
      to_q    <= to_q | to_hit;
    end
  end
  assign rcv_cnt      = rcv_q;
  assign reorder_cnt  = reo_q;
  assign err_misroute = mis_q;
  assign err_dup      = dup_q;
  assign err_range    = rng_q;
  assign err_extra    = ext_q;
  assign timeout      = to_q;
  assign done         = state_q == DONE;
`ifdef PE_SINK_TRACE
  always_ff @(posedge clk) begin
    if (rst_n && vld)
      $display("Received by PE[%0d][%0d]: src=%0h, seq=%0d, %s", X_POS, Y_POS, src, seq,
               misroute ? "misroute" : !in_range ? "range" : hit ? "dup" :
               state_q == DONE ? "extra" : "ok");
  end
`endif
endmodule

// File: tb/tb_pe_sink_checker.sv
// tb_pe_sink_checker: directed plan plus randomized traffic against a behavioural scoreboard model
module tb_pe_sink_checker;
  localparam int XP = 1, YP = 2, MS = 20, EC = 4, TO = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  pe_sink_checker_if #(.P_W(16)) ej();
  logic [15:0] rcv_cnt, reorder_cnt;
  logic err_misroute, err_dup, err_range, err_extra, timeout, done;
  pe_sink_checker #(.P_W(16), .X_AW(2), .Y_AW(2), .X_POS(XP), .Y_POS(YP),
                    .MAX_SEQ(MS), .EXP_CNT(EC), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .ej(ej), .rcv_cnt(rcv_cnt), .reorder_cnt(reorder_cnt),
    .err_misroute(err_misroute), .err_dup(err_dup), .err_range(err_range),
    .err_extra(err_extra), .timeout(timeout), .done(done)
  );
  int n_chk = 0, n_fail = 0;
  bit cmp_en = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // model: set of delivered (src,seq) keys, highest seq per source, counts, flags, phase
  bit seen[int];
  int mx[16];
  bit has[16];
  int m_rcv = 0, m_reo = 0, m_phase = 0, m_quiet = 0;
  bit m_mis = 0, m_dup = 0, m_rng = 0, m_ext = 0, m_to = 0;
  always @(posedge clk) begin
    int prior, d, s, q;
    if (!rst_n) begin
      seen.delete();
      for (int i = 0; i < 16; i++) begin has[i] = 0; mx[i] = 0; end
      m_rcv = 0; m_reo = 0; m_phase = 0; m_quiet = 0;
      m_mis = 0; m_dup = 0; m_rng = 0; m_ext = 0; m_to = 0;
    end else begin
      prior = m_phase;
      d = int'(ej.in_pkt[15:12]);
      s = int'(ej.in_pkt[11:8]);
      q = int'(ej.in_pkt[7:0]);
      if (ej.in_vld) begin
        if (d != XP * 4 + YP) m_mis = 1;
        else if (q >= MS) m_rng = 1;
        else if (seen.exists(s * 256 + q)) m_dup = 1;
        else begin
          seen[s * 256 + q] = 1;
          if (m_rcv < 65535) m_rcv++;
          if (has[s] && q < mx[s]) begin
            if (m_reo < 65535) m_reo++;
          end else begin
            mx[s] = q;
            has[s] = 1;
          end
          if (prior == 2) m_ext = 1;
        end
      end
      if (prior == 1) begin
        if (ej.in_vld) m_quiet = 0;
        else begin
          if (m_quiet + 1 >= TO) m_to = 1;
          m_quiet++;
        end
      end
      if (prior != 2 && m_rcv >= EC) m_phase = 2;
      else if (prior == 0 && ej.in_vld) m_phase = 1;
    end
  end
  always @(negedge clk) begin
    if (cmp_en) begin
      check("rcv_cnt", 32'(rcv_cnt), m_rcv);
      check("reorder_cnt", 32'(reorder_cnt), m_reo);
      check("err_misroute", 32'(err_misroute), 32'(m_mis));
      check("err_dup", 32'(err_dup), 32'(m_dup));
      check("err_range", 32'(err_range), 32'(m_rng));
      check("err_extra", 32'(err_extra), 32'(m_ext));
      check("timeout", 32'(timeout), 32'(m_to));
      check("done", 32'(done), 32'(m_phase == 2));
    end
  end
  task automatic cyc(input bit v, input logic [15:0] p);
    ej.in_vld = v;
    ej.in_pkt = p;
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 16'h0000);
  endtask
  task automatic do_reset;
    rst_n = 1'b0;
    cyc(1'b0, 16'h0000);
    rst_n = 1'b1;
  endtask
  function automatic logic [31:0] flags();
    return {27'd0, err_misroute, err_dup, err_range, err_extra, timeout};
  endfunction
  initial begin
    ej.in_vld = 1'b0;
    ej.in_pkt = 16'h0000;
    do_reset();
    cmp_en = 1;
    check("reset rcv", 32'(rcv_cnt), 0);
    check("reset flags", flags(), 0);
    check("reset done", 32'(done), 0);
    cyc(1, 16'h6000); check("inord rcv1", 32'(rcv_cnt), 1);
    cyc(1, 16'h6001); check("inord rcv2", 32'(rcv_cnt), 2);
    cyc(1, 16'h6D00); check("inord rcv3", 32'(rcv_cnt), 3); check("inord done3", 32'(done), 0);
    cyc(1, 16'h6D01); check("inord rcv4", 32'(rcv_cnt), 4); check("inord done4", 32'(done), 1);
    check("inord reorder", 32'(reorder_cnt), 0);
    check("inord flags", flags(), 0);
    cyc(1, 16'h6D07);
    check("extra flag", 32'(err_extra), 1);
    check("extra rcv", 32'(rcv_cnt), 5);
    check("extra done", 32'(done), 1);
    do_reset();
    cyc(1, 16'h6005);
    cyc(1, 16'h6003);
    check("reord rcv", 32'(rcv_cnt), 2);
    check("reord cnt", 32'(reorder_cnt), 1);
    cyc(1, 16'h6003);
    check("dup flag", 32'(err_dup), 1);
    check("dup rcv", 32'(rcv_cnt), 2);
    do_reset();
    cyc(1, 16'hA000);
    check("misroute flag", 32'(err_misroute), 1);
    check("misroute rcv", 32'(rcv_cnt), 0);
    cyc(1, 16'h6014);
    check("range flag", 32'(err_range), 1);
    check("range rcv", 32'(rcv_cnt), 0);
    idle(7); check("left idle to7", 32'(timeout), 0);
    idle(1); check("left idle to8", 32'(timeout), 1);
    do_reset();
    cyc(1, 16'h6000);
    idle(7); check("to after 7", 32'(timeout), 0);
    idle(1); check("to after 8", 32'(timeout), 1);
    do_reset();
    cyc(1, 16'h6000);
    idle(7);
    cyc(1, 16'h6001); check("to pkt wins", 32'(timeout), 0);
    idle(7); check("to cleared 7", 32'(timeout), 0);
    idle(1); check("to cleared 8", 32'(timeout), 1);
    do_reset();
    cyc(1, 16'h6000);
    cyc(1, 16'h6001);
    rst_n = 1'b0;
    cyc(1, 16'h6002);
    rst_n = 1'b1;
    check("midrst rcv", 32'(rcv_cnt), 0);
    check("midrst flags", flags(), 0);
    check("midrst done", 32'(done), 0);
    cyc(1, 16'h6000);
    check("post rst rcv", 32'(rcv_cnt), 1);
    check("post rst dup", 32'(err_dup), 0);
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      else if ($urandom_range(0, 39) == 0) idle($urandom_range(5, 12));
      else begin
        logic [3:0] d;
        d = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'h6;
        cyc($urandom_range(0, 9) < 7, {d, 4'($urandom_range(0, 15)), 8'($urandom_range(0, 23))});
      end
    end
    cmp_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
